// File: rtl/iomem_pkg.sv
// ---------------------------------------------------------------------------
// iomem_pkg
// Shared definitions for the picosoc iomem router:
//   - router FSM state encoding
//   - default region tag and error read-data word
//   - position of the slot-index field inside the byte address
//   - width of the downstream address bus
// ---------------------------------------------------------------------------
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0]  DEF_REGION   = 8'h03;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  localparam int SLOT_LSB  = 16;
  localparam int SLOT_MSB  = 19;
  localparam int SLOT_W    = SLOT_MSB - SLOT_LSB + 1;

  localparam int DN_ADDR_W = 16;

endpackage

// File: rtl/iomem_rdata_mux.sv
// ---------------------------------------------------------------------------
// iomem_rdata_mux
// NUM_SLOTS:1 multiplexer of 32-bit read-data words.
// Ports:
//   sel_i   latched slot index
//   data_i  flat per-slot read data, slot k at [32k+31:32k]
//   data_o  selected word (zero when the index is out of range)
// ---------------------------------------------------------------------------
module iomem_rdata_mux
  import iomem_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic [SLOT_W-1:0]       sel_i,
  input  logic [32*NUM_SLOTS-1:0] data_i,
  output logic [31:0]             data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (sel_i == SLOT_W'(k)) begin
        data_o = data_i[32*k +: 32];
      end
    end
  end

endmodule

// File: rtl/iomem_router.sv
// ---------------------------------------------------------------------------
// iomem_router
// Address-decoding router and bus watchdog between the picosoc iomem master
// port and up to NUM_SLOTS peripherals. Every output is registered; a slot
// that never answers receives an error response after TIMEOUT cycles.
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   up_valid/up_ready     SoC request / one-cycle response strobe
//   up_wstrb/addr/wdata   SoC request fields (wstrb==0 means read)
//   up_rdata              response data, valid while up_ready
//   dn_valid/dn_ready     one-hot per-slot request / completion strobe
//   dn_addr/wstrb/wdata   latched request fields towards the slots
//   dn_rdata              flat per-slot read data
//   err_pulse/addr/count  error strobe, last error address, saturating count
// ---------------------------------------------------------------------------
module iomem_router
  import iomem_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter int          TIMEOUT   = 64,
  parameter logic [7:0]  REGION    = DEF_REGION,
  parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [3:0]              up_wstrb,
  input  logic [31:0]             up_addr,
  input  logic [31:0]             up_wdata,
  output logic [31:0]             up_rdata,
  output logic [NUM_SLOTS-1:0]    dn_valid,
  input  logic [NUM_SLOTS-1:0]    dn_ready,
  output logic [DN_ADDR_W-1:0]    dn_addr,
  output logic [3:0]              dn_wstrb,
  output logic [31:0]             dn_wdata,
  input  logic [32*NUM_SLOTS-1:0] dn_rdata,
  output logic                    err_pulse,
  output logic [31:0]             err_addr,
  output logic [7:0]              err_count
);

  localparam int                CNT_W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [SLOT_W:0]   SLOT_LIMIT  = (SLOT_W + 1)'(NUM_SLOTS);

  state_t                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    up_ready_q, up_ready_d;
  logic [31:0]             up_rdata_q, up_rdata_d;
  logic [NUM_SLOTS-1:0]    dn_valid_q, dn_valid_d;
  logic [DN_ADDR_W-1:0]    dn_addr_q, dn_addr_d;
  logic [3:0]              dn_wstrb_q, dn_wstrb_d;
  logic [31:0]             dn_wdata_q, dn_wdata_d;
  logic                    err_pulse_q, err_pulse_d;
  logic [31:0]             err_addr_q, err_addr_d;
  logic [7:0]              err_count_q, err_count_d;

  logic [SLOT_W-1:0]       req_slot;
  logic                    claimed;
  logic                    slot_ok;
  logic                    sel_ready;
  logic [31:0]             slot_rdata;

  assign req_slot = up_addr[SLOT_MSB:SLOT_LSB];
  assign claimed  = up_valid && (up_addr[31:24] == REGION);
  assign slot_ok  = {1'b0, req_slot} < SLOT_LIMIT;

  // dn_valid_q is one-hot on the selected slot while ACTIVE, so masking with
  // it discards strobes from every other slot.
  assign sel_ready = |(dn_ready & dn_valid_q);

  iomem_rdata_mux #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_rdata_mux (
    .sel_i  (slot_q),
    .data_i (dn_rdata),
    .data_o (slot_rdata)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    up_ready_d  = up_ready_q;
    up_rdata_d  = up_rdata_q;
    dn_valid_d  = dn_valid_q;
    dn_addr_d   = dn_addr_q;
    dn_wstrb_d  = dn_wstrb_q;
    dn_wdata_d  = dn_wdata_q;
    err_pulse_d = err_pulse_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (claimed) begin
          if (slot_ok) begin
            slot_d     = req_slot;
            dn_addr_d  = up_addr[DN_ADDR_W-1:0];
            dn_wstrb_d = up_wstrb;
            dn_wdata_d = up_wdata;
            dn_valid_d = NUM_SLOTS'(1) << req_slot;
            cnt_d      = '0;
            state_d    = ST_ACTIVE;
          end else begin
            state_d    = ST_ERROR;
          end
        end
      end
      ST_ACTIVE: begin
        // A completion in the final timeout cycle still counts as success.
        if (sel_ready) begin
          up_rdata_d = slot_rdata;
          up_ready_d = 1'b1;
          dn_valid_d = '0;
          state_d    = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          dn_valid_d = '0;
          state_d    = ST_ERROR;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      ST_ERROR: begin
        // up_valid is still held here, so up_addr names the failed request.
        up_ready_d  = 1'b1;
        up_rdata_d  = ERR_DATA;
        err_pulse_d = 1'b1;
        err_addr_d  = up_addr;
        err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        up_ready_d  = 1'b0;
        err_pulse_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      cnt_q       <= '0;
      up_ready_q  <= 1'b0;
      up_rdata_q  <= '0;
      dn_valid_q  <= '0;
      dn_addr_q   <= '0;
      dn_wstrb_q  <= '0;
      dn_wdata_q  <= '0;
      err_pulse_q <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      up_ready_q  <= up_ready_d;
      up_rdata_q  <= up_rdata_d;
      dn_valid_q  <= dn_valid_d;
      dn_addr_q   <= dn_addr_d;
      dn_wstrb_q  <= dn_wstrb_d;
      dn_wdata_q  <= dn_wdata_d;
      err_pulse_q <= err_pulse_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign up_ready  = up_ready_q;
  assign up_rdata  = up_rdata_q;
  assign dn_valid  = dn_valid_q;
  assign dn_addr   = dn_addr_q;
  assign dn_wstrb  = dn_wstrb_q;
  assign dn_wdata  = dn_wdata_q;
  assign err_pulse = err_pulse_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_iomem_router.sv
// ---------------------------------------------------------------------------
// tb_iomem_router
// Randomised bench for iomem_router with a transaction-level reference model:
// each request's response latency, data and error bookkeeping are predicted
// from the slave's chosen wait time and the address alone.
// ---------------------------------------------------------------------------
module tb_iomem_router;

  localparam int          NS      = 4;
  localparam int          TO      = 16;
  localparam logic [7:0]  REG_TAG = 8'h03;
  localparam logic [31:0] ERRWORD = 32'hDEAD_BEEF;

  logic           clk = 1'b0;
  logic           resetn;
  logic           upValid;
  logic           upReady;
  logic [3:0]     upWstrb;
  logic [31:0]    upAddr;
  logic [31:0]    upWdata;
  logic [31:0]    upRdata;
  logic [NS-1:0]  dnValid;
  logic [NS-1:0]  dnReady;
  logic [15:0]    dnAddr;
  logic [3:0]     dnWstrb;
  logic [31:0]    dnWdata;
  logic [32*NS-1:0] dnRdata;
  logic           errPulse;
  logic [31:0]    errAddr;
  logic [7:0]     errCount;

  int             checks = 0;
  int             failures = 0;
  int             modelErrCount = 0;
  logic [31:0]    modelErrAddr = '0;

  // 10-unit clock period
  always #5 clk = ~clk;

  iomem_router #(
    .NUM_SLOTS (NS),
    .TIMEOUT   (TO),
    .REGION    (REG_TAG),
    .ERR_DATA  (ERRWORD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .up_valid  (upValid),
    .up_ready  (upReady),
    .up_wstrb  (upWstrb),
    .up_addr   (upAddr),
    .up_wdata  (upWdata),
    .up_rdata  (upRdata),
    .dn_valid  (dnValid),
    .dn_ready  (dnReady),
    .dn_addr   (dnAddr),
    .dn_wstrb  (dnWstrb),
    .dn_wdata  (dnWdata),
    .dn_rdata  (dnRdata),
    .err_pulse (errPulse),
    .err_addr  (errAddr),
    .err_count (errCount)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All outputs must be at their reset value
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_upReady"},  32'(upReady),  32'd0);
    checkOutput({tag, "_upRdata"},  upRdata,       32'd0);
    checkOutput({tag, "_dnValid"},  32'(dnValid),  32'd0);
    checkOutput({tag, "_dnAddr"},   32'(dnAddr),   32'd0);
    checkOutput({tag, "_dnWstrb"},  32'(dnWstrb),  32'd0);
    checkOutput({tag, "_dnWdata"},  dnWdata,       32'd0);
    checkOutput({tag, "_errPulse"}, 32'(errPulse), 32'd0);
    checkOutput({tag, "_errAddr"},  errAddr,       32'd0);
    checkOutput({tag, "_errCount"}, 32'(errCount), 32'd0);
  endtask

  // One claimed request. waitCyc is the number of cycles the slave waits
  // after first seeing its request before strobing ready; negative means never.
  // Called and returns at a negative clock edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input int waitCyc,
                               input logic [31:0] slotWord);
    int          slot;
    bit          bad;
    bit          expErr;
    int          expLat;
    int          lastValid;
    int          gotLat;
    logic [NS-1:0] oneHot;

    slot   = int'(addr[19:16]);
    bad    = (slot >= NS);
    oneHot = bad ? '0 : (NS'(1) << slot);
    if (bad) begin
      expErr = 1; expLat = 2; lastValid = 0;
    end else if (waitCyc >= 0 && waitCyc <= TO - 1) begin
      expErr = 0; expLat = waitCyc + 2; lastValid = waitCyc + 1;
    end else begin
      expErr = 1; expLat = TO + 2; lastValid = TO;
    end

    for (int k = 0; k < NS; k++) dnRdata[32*k +: 32] = $urandom;
    if (!bad) dnRdata[32*slot +: 32] = slotWord;

    upAddr  = addr;
    upWstrb = wstrb;
    upWdata = wdata;
    upValid = 1'b1;
    gotLat  = 0;

    for (int cyc = 1; cyc <= TO + 10; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      dnReady = '0;
      if (upReady) begin
        gotLat = cyc;
        break;
      end
      checkOutput("dnValid", 32'(dnValid), (cyc <= lastValid) ? 32'(oneHot) : 32'd0);
      checkOutput("errPulseIdle", 32'(errPulse), 32'd0);
      if (cyc <= lastValid) begin
        checkOutput("dnAddr",  32'(dnAddr),  32'(addr[15:0]));
        checkOutput("dnWstrb", 32'(dnWstrb), 32'(wstrb));
        checkOutput("dnWdata", dnWdata, wdata);
      end
      // Noise on unselected slots, then the selected slot's own strobe
      dnReady = NS'($urandom) & ~oneHot;
      if (!bad && waitCyc >= 0 && cyc == waitCyc + 1) dnReady[slot] = 1'b1;
    end

    checkOutput("latency", 32'(gotLat), 32'(expLat));
    if (expErr) begin
      modelErrCount = (modelErrCount < 255) ? modelErrCount + 1 : 255;
      modelErrAddr  = addr;
    end
    checkOutput("upRdata",  upRdata, expErr ? ERRWORD : slotWord);
    checkOutput("errPulse", 32'(errPulse), 32'(expErr));
    checkOutput("errCount", 32'(errCount), 32'(modelErrCount));
    checkOutput("errAddr",  errAddr, modelErrAddr);

    upValid = 1'b0;
    dnReady = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("upReadyDrop",  32'(upReady),  32'd0);
    checkOutput("errPulseDrop", 32'(errPulse), 32'd0);
  endtask

  // Request outside the router's region: nothing may respond or change
  task automatic applyUnclaimed(input logic [31:0] addr);
    upAddr  = addr;
    upWstrb = 4'h0;
    upValid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("unclaimedReady", 32'(upReady), 32'd0);
      checkOutput("unclaimedValid", 32'(dnValid), 32'd0);
    end
    checkOutput("unclaimedErrCount", 32'(errCount), 32'(modelErrCount));
    upValid = 1'b0;
  endtask

  function automatic logic [31:0] randAddr(input bit allowBad);
    logic [3:0] slot;
    slot = allowBad ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, NS - 1));
    return {REG_TAG, 4'($urandom), slot, 16'($urandom)};
  endfunction

  initial begin
    resetn  = 1'b0;
    upValid = 1'b0;
    upWstrb = '0;
    upAddr  = '0;
    upWdata = '0;
    dnReady = '0;
    dnRdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    resetn = 1'b1;

    // Directed cases
    applyStimulus(32'h0300_0004, 4'b0000, 32'h0,   0,      32'h1234_5678);
    applyStimulus(32'h0302_0000, 4'b0001, 32'hA5,  5,      32'h0BAD_F00D);
    applyStimulus(32'h0301_0010, 4'b0000, 32'h0,   -1,     32'h1111_2222);
    applyStimulus(32'h0303_0020, 4'b0000, 32'h0,   TO - 1, 32'h3333_4444);
    applyStimulus(32'h0309_0000, 4'b0000, 32'h0,   0,      32'h0);
    applyUnclaimed(32'h0200_0000);
    applyStimulus(32'h0300_0008, 4'b1111, 32'hCAFE_0001, 2, 32'h5555_6666);

    // Random mix of slots, strobes and wait times
    for (int n = 0; n < 150; n++) begin
      applyStimulus(randAddr(1'b1), 4'($urandom), $urandom,
                    $urandom_range(0, TO + 2) - 1, $urandom);
    end

    // Saturate the error counter with bad-slot requests
    for (int n = 0; n < 300; n++) begin
      applyStimulus({REG_TAG, 4'h0, 4'($urandom_range(NS, 15)), 16'($urandom)},
                    4'h0, 32'h0, 0, 32'h0);
    end
    checkOutput("errCountSat", 32'(errCount), 32'd255);

    // Reset while slot 3 is stalled
    upAddr  = 32'h0303_0040;
    upWstrb = 4'b0011;
    upWdata = 32'h7777_8888;
    upValid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("preResetValid", 32'(dnValid), 32'b1000);
    resetn  = 1'b0;
    upValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetState("midReset");
    resetn = 1'b1;
    modelErrCount = 0;
    modelErrAddr  = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("noLateReady", 32'(upReady), 32'd0);
    applyStimulus(32'h0303_0040, 4'b0000, 32'h0, 1, 32'h9999_AAAA);

    // A few more random transactions after reset
    for (int n = 0; n < 30; n++) begin
      applyStimulus(randAddr(1'b0), 4'($urandom), $urandom,
                    $urandom_range(0, TO + 2) - 1, $urandom);
    end
    applyUnclaimed({8'h7F, 24'($urandom)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iomem_router.md
# iomem_router

Address-decoding router and bus-watchdog for the picosoc `iomem` port. It sits between the SoC's `iomem_*` master interface and up to `NUM_SLOTS` board peripherals such as GPIO, timer and PWM. It gives each peripheral a registered valid/ready handshake. It also guarantees the CPU never hangs: an absent or stalled peripheral receives an error response after a bounded time.

## Interface
- `NUM_SLOTS`, 4: number of downstream slots, 1..16.
- `TIMEOUT`, 64: cycles a selected slot may stall before an error response; minimum 2.
- `REGION`, 8'h03: value of `up_addr[31:24]` that the router claims.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on any error response.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `up_valid`  in  1  request from SoC; held until `up_ready`.
- `up_ready`  out  1  one-cycle response strobe; reset 0.
- `up_wstrb`  in  4  byte write strobes; 0 means read.
- `up_addr`  in  32  byte address.
- `up_wdata`  in  32  write data.
- `up_rdata`  out  32  read data, valid while `up_ready`=1; reset 0.
- `dn_valid`  out  NUM_SLOTS  one-hot request to the selected slot; reset 0.
- `dn_ready`  in  NUM_SLOTS  per-slot completion strobe.
- `dn_addr`  out  16  registered `up_addr[15:0]`; reset 0.
- `dn_wstrb`  out  4  registered strobes; reset 0.
- `dn_wdata`  out  32  registered write data; reset 0.
- `dn_rdata`  in  32*NUM_SLOTS  flat per-slot read data; slot k occupies `[32k+31:32k]`.
- `err_pulse`  out  1  one-cycle strobe on each error response; reset 0.
- `err_addr`  out  32  address of the most recent error; reset 0.
- `err_count`  out  8  saturating error counter; reset 0.

## Operation
- The slot index is `up_addr[19:16]`. The router claims a request only when `up_addr[31:24]==REGION`. Unclaimed requests are ignored and no output changes.
- The FSM has four states: IDLE, ACTIVE, ERROR, DONE. The reset state is IDLE.
- **IDLE**, claimed `up_valid`, slot < NUM_SLOTS:
  - latch `dn_addr`, `dn_wstrb` and `dn_wdata`;
  - set `dn_valid[slot]`;
  - clear the timeout counter;
  - go to ACTIVE.
- **IDLE**, claimed `up_valid`, slot >= NUM_SLOTS: go to ERROR. No `dn_valid` is raised.
- **ACTIVE**:
  - If `dn_ready[slot]`=1: `up_rdata`<=slot rdata, `up_ready`<=1, `dn_valid`<=0, go to DONE.
  - Else, if counter==TIMEOUT-1: go to ERROR and drop `dn_valid`.
  - Otherwise, increment the counter.
- **ERROR**:
  - `up_ready`<=1 and `up_rdata`<=ERR_DATA;
  - `err_pulse`<=1 and `err_addr`<=`up_addr`;
  - `err_count`<=min(count+1, 255);
  - go to DONE.
  - A write that ends in error is dropped.
- **DONE**: `up_ready`<=0, `err_pulse`<=0, go to IDLE. `up_valid` is ignored during DONE.
- `dn_ready` from an unselected slot is ignored. `dn_ready` seen in any state other than ACTIVE is also ignored.
- `dn_ready` and timeout in the same cycle: ready wins, and no error is raised.
- Reset mid-transaction forces every output to its reset value within the same edge. No late `up_ready` is issued after reset.

## Timing
- The zero-wait slave path takes 3 cycles: claim at edge 0, `dn_valid` high from edge 1, slave `dn_ready` in the same cycle, `up_ready` high from edge 2 for exactly 1 cycle.
- For a slave with W wait cycles after `dn_valid`, `up_ready` rises W cycles after the zero-wait case.
- The timeout response has `up_ready` high TIMEOUT+2 cycles after the claim edge.
- A bad slot index gives `up_ready` 2 cycles after the claim edge.
- Back-to-back: a new claim is accepted in the IDLE cycle following DONE. Minimum spacing is 4 cycles per transaction.
- `dn_valid` is held until `dn_ready` or timeout. `dn_addr`, `dn_wstrb` and `dn_wdata` are stable while `dn_valid`=1.
- All outputs are registered, so there is no combinational path from `up_*` to `dn_*` or the reverse.

## Structure
- Package `iomem_pkg` holds:
  - the state enum (IDLE, ACTIVE, ERROR, DONE);
  - default constants for REGION and ERR_DATA;
  - slot-field bit positions [19:16];
  - the `dn_addr` width of 16.
- Sub-module `iomem_rdata_mux` is a parameterised NUM_SLOTS:1 mux of 32-bit words selected by the latched slot index. The FSM, timeout counter and error registers stay in `iomem_router`.

## Test plan
- **Zero-wait read:** slot 0 read at 0x0300_0004, slave returns 0x1234_5678 with `dn_ready` at the first `dn_valid` cycle -> `up_ready` 2 cycles after claim, `up_rdata`=0x1234_5678, `dn_addr`=0x0004.
- **Wait-state write:** write 0xA5 with wstrb=4'b0001 to 0x0302_0000; slot 2 asserts ready after 5 cycles -> `dn_wstrb`=0001 and `dn_wdata` stable throughout, `up_ready` at claim+7, `err_count` stays 0.
- **Timeout:** TIMEOUT=16, slot 1 never ready -> `dn_valid[1]` drops after 16 cycles, `up_ready` at claim+18 with ERR_DATA, `err_pulse` for 1 cycle, `err_addr`=request address, `err_count`=1.
- **Bad slot:** NUM_SLOTS=4, read 0x0309_0000 -> no `dn_valid`, `up_ready` at claim+2 with 0xDEAD_BEEF; repeated 300 times -> `err_count` saturates at 255.
- **Reset mid-transaction:** `resetn` low while ACTIVE on slot 3 -> next edge `dn_valid`=0, `up_ready`=0, FSM in IDLE; a following request completes normally.
- **Edge cases:**
  - `dn_ready` on an unselected slot is ignored.
  - `dn_ready` coinciding with the timeout cycle -> normal data response, no error.
  - A request with `up_addr[31:24]`=0x02 -> no response from the router.
